qam_depacketizer: RTL and testbench
===================================

# qam_depacketizer

Demodulator-side counterpart of the modulator streamer. Takes demodulated 4-bit QAM symbols and reassembles them into 16-bit words, least-significant nibble first. Buffers the words in a FIFO and returns them to the host as UART_PACKET byte streams, each word sent as lower byte then upper byte. Sits between the QAM symbol decider and the UART transmitter.

## Interface
- FIFO_DEPTH, 4096: word FIFO depth; power of two.
- WORDS_PER_PACKET, 8: words per full packet; range 1..127.
- FLUSH_CYCLES, 25000000: idle cycles before a partial packet is flushed.
- SRC_ADDR, 8'h20: Source field of emitted packets.
- DST_ADDR, 8'hAA: Destination field of emitted packets.
- ipClk  in  1  clock.
- nReset  in  1  reset, synchronous, active-high.
- ipQAMBlock  in  4  demodulated symbol.
- ipQAMBlockValid  in  1  symbol strobe, one cycle per symbol.
- ipSymbolSync  in  1  frame start; clears nibble position.
- opWord  out  16  last assembled word.
- opWordValid  out  1  one-cycle pulse per assembled word.
- opFIFO_Size  out  13  words currently in FIFO.
- opOverflow  out  1  sticky; set when a word is dropped because the FIFO is full.
- opTxStream  out  UART_PACKET  byte stream to the UART transmitter.
- ipTxReady  in  1  transmitter can accept a byte.

## Operation
- Nibble assembly:
  - 2-bit position counter; each valid symbol is written to word[4*pos+3 : 4*pos], then pos increments.
  - At pos==3: opWord <= completed word, opWordValid=1 next cycle, FIFO write issued the same cycle.
  - If the FIFO is full at write time, the word is dropped and opOverflow=1 (cleared only by reset).
- ipSymbolSync:
  - Sets pos=0 and discards any partial word.
  - If it coincides with ipQAMBlockValid, that symbol is taken as nibble 0.
- FIFO behaviour:
  - Read data is registered: Q is valid the cycle after RdEn.
  - Simultaneous write and read are legal; the count changes by net zero.
- Tx FSM states: Idle, Load, Latch, SendLo, GapLo, SendHi, GapHi.
  - Idle: start a packet when count ≥ WORDS_PER_PACKET (N = WORDS_PER_PACKET), or when the flush timer reaches FLUSH_CYCLES with count > 0 (N = min(count, WORDS_PER_PACKET)). Start means: latch N, set Length = 2N, go to Load.
  - Load: assert RdEn for one cycle.
  - Latch: capture Q into the word register.
  - SendLo / SendHi: wait for ipTxReady=1, then drive Valid=1 for exactly one cycle with Data = lower byte (SendLo) or upper byte (SendHi).
  - GapLo / GapHi: one mandatory cycle with Valid=0. GapLo goes to SendHi. GapHi goes to Load if words remain, otherwise to Idle.
- Packet framing:
  - SoP=1 on the first byte only; EoP=1 on the last byte only.
  - Length, Source and Destination are constant through the packet.
- Flush timer:
  - Counts while in Idle with count > 0.
  - Clears on packet start or whenever the FIFO is empty.
  - Saturates at FLUSH_CYCLES.
- Symbol intake never stalls; transmission runs concurrently with intake.

## Timing
- Reset values: opWord=0, opWordValid=0, opFIFO_Size=0, opOverflow=0. opTxStream: Valid=SoP=EoP=0, Length=0, Data=0, Source=SRC_ADDR, Destination=DST_ADDR. FSM=Idle, pos=0, timer=0, FIFO emptied.
- Symbol-to-word latency: opWordValid one cycle after the 4th valid symbol is sampled. opFIFO_Size updates in the same cycle.
- Packet-start latency: FIFO threshold reached → first Valid pulse after at least 3 cycles (Idle→Load→Latch→SendLo), plus any ipTxReady wait.
- Minimum byte spacing is 2 cycles. The transmitter must deassert ipTxReady within one cycle of accepting a byte.
- Reset mid-packet: the packet is abandoned with no EoP. The host discards the truncated packet on the next SoP.
- Widths:
  - Length is 8 bits; 2N ≤ 254.
  - opFIFO_Size is 13 bits and reports values up to FIFO_DEPTH.

## Structure
- Shared Structures package:
  - UART_PACKET: Valid, SoP, EoP, Length[7:0], Source[7:0], Destination[7:0], Data[7:0].
  - Address constants ADDR_HOST=8'hAA, ADDR_MOD=8'h10, ADDR_DEMOD=8'h20.
  - Tx FSM enum.
- One sub-module, word_fifo: synchronous FIFO with registered Q, plus Empty, Full and a 13-bit count.
- Top-level pieces: nibble assembler, flush timer, Tx FSM.

## Test plan
- Symbols 4,3,2,1 → opWord=16'h1234, one opWordValid pulse, opFIFO_Size=1.
- 8 words 0x0001..0x0008 with ipTxReady held high → 16 bytes 01,00,02,00,…,08,00. Length=16; SoP on the first byte only, EoP on the last only; Source 0x20, Destination 0xAA; FIFO returns to 0.
- 3 words, then silence, with FLUSH_CYCLES=100 → Length=6 packet starts about 100 cycles after the last write, before which no Valid pulse occurs.
- 2 symbols, then ipSymbolSync, then symbols A,B,C,D → opWord=16'hDCBA; the partial word is discarded.
- Fill to FIFO_DEPTH with ipTxReady=0, then one more word → opOverflow=1, opFIFO_Size=4096, the extra word is absent from the output.
- nReset asserted after 5 bytes of a packet → all outputs at reset values the next cycle; the next packet starts with a fresh SoP.

Source files
------------

// File: rtl/qam_depacketizer_pkg.sv
// Shared types and constants for the QAM demodulator-side depacketizer:
// UART packet record, node addresses and the transmit state encoding.
package qam_depacketizer_pkg;

   localparam int COUNT_W = 13;

   localparam logic [7:0] ADDR_HOST  = 8'hAA;
   localparam logic [7:0] ADDR_MOD   = 8'h10;
   localparam logic [7:0] ADDR_DEMOD = 8'h20;

   typedef struct packed {
      logic       Valid;
      logic       SoP;
      logic       EoP;
      logic [7:0] Length;
      logic [7:0] Source;
      logic [7:0] Destination;
      logic [7:0] Data;
   } UART_PACKET;

   typedef enum logic [2:0] {
      TX_IDLE    = 3'd0,
      TX_LOAD    = 3'd1,
      TX_LATCH   = 3'd2,
      TX_SEND_LO = 3'd3,
      TX_GAP_LO  = 3'd4,
      TX_SEND_HI = 3'd5,
      TX_GAP_HI  = 3'd6
   } tx_state_t;

   // Two bytes go out per word.
   function automatic logic [7:0] packet_length(input logic [6:0] n_words);
      return {n_words, 1'b0};
   endfunction

endpackage

// File: rtl/qam_depacketizer_if.sv
// Byte stream towards the UART transmitter together with its ready back-pressure.
interface qam_depacketizer_if;
   import qam_depacketizer_pkg::*;

   UART_PACKET opTxStream;
   logic       ipTxReady;

   modport master (output opTxStream, input ipTxReady);
   modport slave  (input opTxStream, output ipTxReady);

endinterface

// File: rtl/qam_depacketizer_word_fifo.sv
// Synchronous 16-bit word FIFO with registered read data (Q valid the cycle after a read).
// Writes while full and reads while empty are ignored.
module qam_depacketizer_word_fifo
   import qam_depacketizer_pkg::*;
#(
   parameter int DEPTH = 4096
)(
   input  logic               ipClk,
   input  logic               nReset,
   input  logic               i_wr_en,
   input  logic [15:0]        i_wr_data,
   input  logic               i_rd_en,
   output logic [15:0]        o_rd_data,
   output logic               o_empty,
   output logic               o_full,
   output logic [COUNT_W-1:0] o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [15:0]        r_mem [DEPTH];
   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_rd_ptr;
   logic [COUNT_W-1:0] r_count;
   logic [15:0]        r_q;
   logic               w_wr;
   logic               w_rd;

   assign o_empty   = (r_count == COUNT_W'(0));
   assign o_full    = (r_count == COUNT_W'(DEPTH));
   assign w_wr      = i_wr_en && !o_full;
   assign w_rd      = i_rd_en && !o_empty;
   assign o_rd_data = r_q;
   assign o_count   = r_count;

   // Storage array; contents need no reset since the pointers define validity.
   always_ff @(posedge ipClk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   // Pointers, occupancy and registered read data.
   always_ff @(posedge ipClk) begin
      if (nReset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_q      <= 16'h0000;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
            r_q      <= r_mem[r_rd_ptr];
         end
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + COUNT_W'(1);
            2'b01:   r_count <= r_count - COUNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/qam_depacketizer.sv
// Reassembles 4-bit QAM symbols into 16-bit words (LS nibble first), buffers them and
// returns them to the host as UART packets, lower byte of each word first.
module qam_depacketizer
   import qam_depacketizer_pkg::*;
#(
   parameter int         FIFO_DEPTH       = 4096,
   parameter int         WORDS_PER_PACKET = 8,
   parameter int         FLUSH_CYCLES     = 25000000,
   parameter logic [7:0] SRC_ADDR         = ADDR_DEMOD,
   parameter logic [7:0] DST_ADDR         = ADDR_HOST
)(
   input  logic               ipClk,
   input  logic               nReset,
   input  logic [3:0]         ipQAMBlock,
   input  logic               ipQAMBlockValid,
   input  logic               ipSymbolSync,
   output logic [15:0]        opWord,
   output logic               opWordValid,
   output logic [COUNT_W-1:0] opFIFO_Size,
   output logic               opOverflow,
   qam_depacketizer_if.master tx_if
);

   localparam logic [COUNT_W-1:0] WPP_COUNT   = COUNT_W'(WORDS_PER_PACKET);
   localparam logic [6:0]         WPP_WORDS   = 7'(WORDS_PER_PACKET);
   localparam logic [31:0]        FLUSH_LIMIT = 32'(FLUSH_CYCLES);

   logic [1:0]         r_pos;
   logic [11:0]        r_partial;
   logic [15:0]        r_word;
   logic               r_word_valid;
   logic               r_overflow;
   logic               w_wr_en;
   logic [15:0]        w_wr_data;
   logic [15:0]        w_fifo_q;
   logic               w_fifo_empty;
   logic               w_fifo_full;
   logic [COUNT_W-1:0] w_fifo_count;
   logic [31:0]        r_flush_cnt;
   logic               w_flush_due;
   tx_state_t          r_state;
   tx_state_t          w_next_state;
   logic               w_rd_en;
   logic               w_start;
   logic [6:0]         w_start_n;
   logic               w_emit_lo;
   logic               w_emit_hi;
   logic [6:0]         r_words_left;
   logic [15:0]        r_tx_word;
   logic               r_first;
   UART_PACKET         r_tx;

   // The fourth nibble completes the word straight from the input, so the FIFO write
   // lands on the same edge that raises opWordValid.
   assign w_wr_en   = ipQAMBlockValid && !ipSymbolSync && (r_pos == 2'd3);
   assign w_wr_data = {ipQAMBlock, r_partial};

   // Nibble assembler, word output register and sticky overflow flag.
   always_ff @(posedge ipClk) begin
      if (nReset) begin
         r_pos        <= 2'd0;
         r_partial    <= 12'h000;
         r_word       <= 16'h0000;
         r_word_valid <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_word_valid <= 1'b0;
         if (w_wr_en && w_fifo_full) begin
            r_overflow <= 1'b1;
         end
         if (ipSymbolSync) begin
            r_pos <= ipQAMBlockValid ? 2'd1 : 2'd0;
            if (ipQAMBlockValid) begin
               r_partial[3:0] <= ipQAMBlock;
            end
         end else if (ipQAMBlockValid) begin
            r_pos <= r_pos + 2'd1;
            case (r_pos)
               2'd0:    r_partial[3:0]  <= ipQAMBlock;
               2'd1:    r_partial[7:4]  <= ipQAMBlock;
               2'd2:    r_partial[11:8] <= ipQAMBlock;
               default: begin
                  r_word       <= w_wr_data;
                  r_word_valid <= 1'b1;
               end
            endcase
         end
      end
   end

   qam_depacketizer_word_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_word_fifo (
      .ipClk     (ipClk),
      .nReset    (nReset),
      .i_wr_en   (w_wr_en),
      .i_wr_data (w_wr_data),
      .i_rd_en   (w_rd_en),
      .o_rd_data (w_fifo_q),
      .o_empty   (w_fifo_empty),
      .o_full    (w_fifo_full),
      .o_count   (w_fifo_count)
   );

   assign w_flush_due = (r_flush_cnt == FLUSH_LIMIT) && !w_fifo_empty;

   // Flush timer: runs only while idle with data waiting, saturating at the limit.
   always_ff @(posedge ipClk) begin
      if (nReset) begin
         r_flush_cnt <= 32'd0;
      end else if (w_start || w_fifo_empty) begin
         r_flush_cnt <= 32'd0;
      end else if ((r_state == TX_IDLE) && (r_flush_cnt != FLUSH_LIMIT)) begin
         r_flush_cnt <= r_flush_cnt + 32'd1;
      end else begin
         r_flush_cnt <= r_flush_cnt;
      end
   end

   // Tx state register.
   always_ff @(posedge ipClk) begin
      if (nReset) begin
         r_state <= TX_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Tx next-state and control decode.
   always_comb begin
      w_next_state = r_state;
      w_rd_en      = 1'b0;
      w_start      = 1'b0;
      w_start_n    = 7'd0;
      w_emit_lo    = 1'b0;
      w_emit_hi    = 1'b0;
      case (r_state)
         TX_IDLE: begin
            if (w_fifo_count >= WPP_COUNT) begin
               w_start      = 1'b1;
               w_start_n    = WPP_WORDS;
               w_next_state = TX_LOAD;
            end else if (w_flush_due) begin
               w_start      = 1'b1;
               w_start_n    = w_fifo_count[6:0];
               w_next_state = TX_LOAD;
            end else begin
               w_next_state = TX_IDLE;
            end
         end
         TX_LOAD: begin
            w_rd_en      = 1'b1;
            w_next_state = TX_LATCH;
         end
         TX_LATCH: w_next_state = TX_SEND_LO;
         TX_SEND_LO: begin
            if (tx_if.ipTxReady) begin
               w_emit_lo    = 1'b1;
               w_next_state = TX_GAP_LO;
            end else begin
               w_next_state = TX_SEND_LO;
            end
         end
         TX_GAP_LO: w_next_state = TX_SEND_HI;
         TX_SEND_HI: begin
            if (tx_if.ipTxReady) begin
               w_emit_hi    = 1'b1;
               w_next_state = TX_GAP_HI;
            end else begin
               w_next_state = TX_SEND_HI;
            end
         end
         TX_GAP_HI: begin
            if (r_words_left != 7'd0) begin
               w_next_state = TX_LOAD;
            end else begin
               w_next_state = TX_IDLE;
            end
         end
         default: w_next_state = TX_IDLE;
      endcase
   end

   // Packet datapath: word countdown, word latch and the registered byte stream.
   always_ff @(posedge ipClk) begin
      if (nReset) begin
         r_words_left <= 7'd0;
         r_tx_word    <= 16'h0000;
         r_first      <= 1'b0;
         r_tx         <= '{Valid: 1'b0, SoP: 1'b0, EoP: 1'b0, Length: 8'h00,
                           Source: SRC_ADDR, Destination: DST_ADDR, Data: 8'h00};
      end else begin
         r_tx.Valid       <= 1'b0;
         r_tx.SoP         <= 1'b0;
         r_tx.EoP         <= 1'b0;
         r_tx.Source      <= SRC_ADDR;
         r_tx.Destination <= DST_ADDR;
         if (w_start) begin
            r_words_left <= w_start_n;
            r_tx.Length  <= packet_length(w_start_n);
            r_first      <= 1'b1;
         end
         if (w_rd_en) begin
            r_words_left <= r_words_left - 7'd1;
         end
         if (r_state == TX_LATCH) begin
            r_tx_word <= w_fifo_q;
         end
         if (w_emit_lo) begin
            r_tx.Valid <= 1'b1;
            r_tx.SoP   <= r_first;
            r_tx.Data  <= r_tx_word[7:0];
            r_first    <= 1'b0;
         end
         // The countdown already reached zero at Load when this is the packet's last word.
         if (w_emit_hi) begin
            r_tx.Valid <= 1'b1;
            r_tx.EoP   <= (r_words_left == 7'd0);
            r_tx.Data  <= r_tx_word[15:8];
         end
      end
   end

   assign opWord           = r_word;
   assign opWordValid      = r_word_valid;
   assign opFIFO_Size      = w_fifo_count;
   assign opOverflow       = r_overflow;
   assign tx_if.opTxStream = r_tx;

endmodule

// File: tb/tb_qam_depacketizer.sv
// Self-checking bench: directed and randomized symbol streams against a queue-based
// packet model (words grouped into packets, each word emitted low byte then high byte).
module tb_qam_depacketizer;
   import qam_depacketizer_pkg::*;

   localparam int         DEPTH = 4096;
   localparam int         WPP   = 8;
   localparam int         FLUSH = 100;
   localparam logic [7:0] SRC   = 8'h20;
   localparam logic [7:0] DST   = 8'hAA;

   typedef struct packed {
      logic [7:0] data;
      logic       sop;
      logic       eop;
      logic [7:0] len;
      logic [7:0] src;
      logic [7:0] dst;
   } rec_t;

   logic        ipClk = 1'b0;
   logic        nReset;
   logic [3:0]  ipQAMBlock;
   logic        ipQAMBlockValid;
   logic        ipSymbolSync;
   logic [15:0] opWord;
   logic        opWordValid;
   logic [12:0] opFIFO_Size;
   logic        opOverflow;

   qam_depacketizer_if tx_if ();

   int          errors = 0;
   int          checks = 0;
   bit          rand_ready = 1'b0;
   logic        ready_level = 1'b1;
   logic [15:0] word_q [$];
   rec_t        exp_q [$];
   rec_t        obs_q [$];

   always #5 ipClk = ~ipClk;

   qam_depacketizer #(
      .FIFO_DEPTH       (DEPTH),
      .WORDS_PER_PACKET (WPP),
      .FLUSH_CYCLES     (FLUSH),
      .SRC_ADDR         (SRC),
      .DST_ADDR         (DST)
   ) dut (
      .ipClk           (ipClk),
      .nReset          (nReset),
      .ipQAMBlock      (ipQAMBlock),
      .ipQAMBlockValid (ipQAMBlockValid),
      .ipSymbolSync    (ipSymbolSync),
      .opWord          (opWord),
      .opWordValid     (opWordValid),
      .opFIFO_Size     (opFIFO_Size),
      .opOverflow      (opOverflow),
      .tx_if           (tx_if)
   );

   // Byte monitor on the falling edge.
   always @(negedge ipClk) begin
      if (tx_if.opTxStream.Valid === 1'b1) begin
         obs_q.push_back(rec_t'({tx_if.opTxStream.Data, tx_if.opTxStream.SoP,
                                 tx_if.opTxStream.EoP, tx_if.opTxStream.Length,
                                 tx_if.opTxStream.Source, tx_if.opTxStream.Destination}));
      end
   end

   // Transmitter ready: held level or random.
   initial begin
      tx_if.ipTxReady = 1'b0;
      forever begin
         @(posedge ipClk);
         #1;
         if (rand_ready) tx_if.ipTxReady = ($urandom_range(0, 2) != 0);
         else            tx_if.ipTxReady = ready_level;
      end
   end

   task automatic tick();
      @(posedge ipClk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_symbol(input logic [3:0] nib, input bit sync);
      ipQAMBlock      = nib;
      ipQAMBlockValid = 1'b1;
      ipSymbolSync    = sync;
      tick();
      ipQAMBlockValid = 1'b0;
      ipSymbolSync    = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] w, input bit sync_first,
                            input int gap_max, input bit accepted);
      for (int i = 0; i < 4; i++) begin
         if (i > 0 && gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
         send_symbol(w[4*i +: 4], sync_first && (i == 0));
      end
      chk("word_valid", 64'(opWordValid), 64'd1);
      chk("word", 64'(opWord), 64'(w));
      if (accepted) word_q.push_back(w);
   endtask

   // Groups pending words into packets of WPP; with flush, the remainder forms a short packet.
   task automatic form_packets(input bit flush);
      int          n;
      logic [15:0] w;
      while (word_q.size() >= WPP || (flush && word_q.size() > 0)) begin
         n = (word_q.size() >= WPP) ? WPP : word_q.size();
         for (int i = 0; i < n; i++) begin
            w = word_q.pop_front();
            exp_q.push_back(rec_t'({w[7:0],  (i == 0), 1'b0, 8'(2 * n), SRC, DST}));
            exp_q.push_back(rec_t'({w[15:8], 1'b0, (i == n - 1), 8'(2 * n), SRC, DST}));
         end
      end
   endtask

   task automatic compare_stream(input string tag, input int budget);
      int k = 0;
      while (obs_q.size() < exp_q.size() && k < budget) begin
         tick();
         k++;
      end
      chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         chk(tag, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic check_reset_values();
      chk("rst_word",        64'(opWord), 64'd0);
      chk("rst_word_valid",  64'(opWordValid), 64'd0);
      chk("rst_fifo_size",   64'(opFIFO_Size), 64'd0);
      chk("rst_overflow",    64'(opOverflow), 64'd0);
      chk("rst_valid",       64'(tx_if.opTxStream.Valid), 64'd0);
      chk("rst_sop",         64'(tx_if.opTxStream.SoP), 64'd0);
      chk("rst_eop",         64'(tx_if.opTxStream.EoP), 64'd0);
      chk("rst_length",      64'(tx_if.opTxStream.Length), 64'd0);
      chk("rst_data",        64'(tx_if.opTxStream.Data), 64'd0);
      chk("rst_source",      64'(tx_if.opTxStream.Source), 64'(SRC));
      chk("rst_destination", 64'(tx_if.opTxStream.Destination), 64'(DST));
   endtask

   initial begin
      int          k;
      logic [15:0] w;

      nReset          = 1'b1;
      ipQAMBlock      = 4'h0;
      ipQAMBlockValid = 1'b0;
      ipSymbolSync    = 1'b0;
      ready_level     = 1'b1;
      repeat (3) tick();
      check_reset_values();
      nReset = 1'b0;
      tick();

      // Symbols 4,3,2,1 -> 0x1234, single pulse, then flushed as a 1-word packet.
      send_word(16'h1234, 1'b0, 0, 1'b1);
      chk("fifo_size_one", 64'(opFIFO_Size), 64'd1);
      tick();
      chk("word_valid_pulse", 64'(opWordValid), 64'd0);
      form_packets(1'b1);
      compare_stream("flush_single", 400);

      // Three words then silence: flush packet about FLUSH cycles later.
      for (int i = 0; i < 3; i++) send_word(16'($urandom), 1'b0, 0, 1'b1);
      k = 0;
      while (obs_q.size() == 0 && k < 400) begin
         tick();
         k++;
      end
      chk("flush_not_early", 64'(k >= 90), 64'd1);
      chk("flush_not_late",  64'(k <= 110), 64'd1);
      form_packets(1'b1);
      compare_stream("flush_packet", 200);

      // Full packet of words 1..8 with ready held high.
      for (int i = 1; i <= 8; i++) send_word(16'(i), 1'b0, 0, 1'b1);
      form_packets(1'b0);
      compare_stream("full_packet", 200);
      chk("fifo_drained", 64'(opFIFO_Size), 64'd0);

      // Symbol sync discards partial words, with and without a coincident symbol.
      send_symbol(4'h5, 1'b0);
      send_symbol(4'h6, 1'b0);
      send_word(16'hDCBA, 1'b1, 0, 1'b1);
      send_symbol(4'h7, 1'b0);
      ipSymbolSync = 1'b1;
      tick();
      ipSymbolSync = 1'b0;
      w = 16'($urandom);
      send_word(w, 1'b0, 1, 1'b1);
      chk("sync_fifo_size", 64'(opFIFO_Size), 64'd2);
      form_packets(1'b1);
      compare_stream("sync_packet", 400);

      // Random words, random symbol gaps, random transmitter readiness.
      rand_ready = 1'b1;
      for (int i = 0; i < 20; i++) send_word(16'($urandom), 1'b0, 1, 1'b1);
      form_packets(1'b1);
      compare_stream("random", 3000);
      rand_ready  = 1'b0;
      ready_level = 1'b0;

      // Fill to FIFO_DEPTH with the transmitter stalled, then one dropped word.
      k = 0;
      while (opFIFO_Size != 13'(DEPTH) && k < 4200) begin
         send_word(16'($urandom), 1'b0, 0, 1'b1);
         k++;
      end
      chk("fill_size", 64'(opFIFO_Size), 64'(DEPTH));
      chk("no_overflow_yet", 64'(opOverflow), 64'd0);
      send_word(16'($urandom), 1'b0, 0, 1'b0);
      chk("overflow_set", 64'(opOverflow), 64'd1);
      chk("overflow_size", 64'(opFIFO_Size), 64'(DEPTH));
      ready_level = 1'b1;
      form_packets(1'b1);
      compare_stream("drain", 60000);
      chk("overflow_sticky", 64'(opOverflow), 64'd1);

      // Reset after five bytes of a packet, then a fresh packet.
      for (int i = 0; i < 8; i++) send_word(16'($urandom), 1'b0, 0, 1'b1);
      form_packets(1'b0);
      k = 0;
      while (obs_q.size() < 5 && k < 200) begin
         tick();
         k++;
      end
      chk("trunc_count", 64'(obs_q.size()), 64'd5);
      nReset = 1'b1;
      tick();
      check_reset_values();
      nReset = 1'b0;
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         chk("trunc_byte", 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
      end
      obs_q.delete();
      exp_q.delete();
      word_q.delete();
      tick();
      for (int i = 0; i < 8; i++) send_word(16'($urandom), 1'b0, 0, 1'b1);
      form_packets(1'b0);
      compare_stream("after_reset", 200);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
